// File: rtl/pipe_ctrl.sv
// Pipeline control for a five-stage in-order core: ID decode, staged control
// bundles, load-use/branch hazard stalls, EX forwarding and a STOP drain FSM.
module pipe_ctrl #(
    parameter int ADDR_W    = 64,
    parameter int INST_W    = 32,
    parameter int DATA_W    = 64,
    parameter int REG_W     = 5,
    parameter int DRAIN_CYC = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [INST_W-1:0] id_inst,
    input  logic              id_valid,
    input  logic              br_taken,
    input  logic              dmem_stall,
    output logic              id_branch,
    output logic [2:0]        ex_ctrl,
    output logic [1:0]        mem_ctrl,
    output logic [1:0]        wb_ctrl,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  mem_rd,
    output logic [REG_W-1:0]  wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              done
);

    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_STOP = 7'b1111111;

    localparam int CNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYC - 1);
    localparam int UNUSED_WIDTHS = ADDR_W + DATA_W;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt, next_cnt;

    logic [6:0]        opcode;
    logic [REG_W-1:0]  id_rs1, id_rs2, id_rd;
    logic [2:0]        dec_ex;
    logic [1:0]        dec_mem, dec_wb;
    logic              dec_br, use_rs1, use_rs2, id_stop;

    logic [1:0]        ex_mem_b, ex_wb_b, mem_wb_b;
    logic [REG_W-1:0]  ex_rs1, ex_rs2;
    logic              load_use, br_stall, hz_stall, issue;
    logic              unused_bits;

    assign opcode      = id_inst[6:0];
    assign id_rd       = REG_W'(id_inst[11:7]);
    assign id_rs1      = REG_W'(id_inst[19:15]);
    assign id_rs2      = REG_W'(id_inst[24:20]);
    assign unused_bits = ^{id_inst[INST_W-1:25], id_inst[14:12]};

    // Bundle layout: EX {ALUOp[1:0],ALUSrc}, MEM {MemRead,MemWrite}, WB {MemtoReg,RegWrite}.
    always_comb begin
        dec_ex  = 3'b000;
        dec_mem = 2'b00;
        dec_wb  = 2'b00;
        dec_br  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        if (id_valid) begin
            case (opcode)
                OP_LD: begin
                    dec_ex = 3'b001; dec_mem = 2'b10; dec_wb = 2'b11; use_rs1 = 1'b1;
                end
                OP_SD: begin
                    dec_ex = 3'b001; dec_mem = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_BR: begin
                    dec_ex = 3'b110; dec_br = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                OP_I: begin
                    dec_ex = 3'b001; dec_wb = 2'b01; use_rs1 = 1'b1;
                end
                OP_R: begin
                    dec_wb = 2'b01; use_rs1 = 1'b1; use_rs2 = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign id_stop   = id_valid && (opcode == OP_STOP);
    assign id_branch = dec_br;

    // Branches resolve in ID, so they also wait on an ALU result in EX or a load in MEM.
    assign load_use = (state == RUN) && ex_mem_b[1] && (ex_rd != '0) &&
                      ((use_rs1 && (ex_rd == id_rs1)) || (use_rs2 && (ex_rd == id_rs2)));
    assign br_stall = (state == RUN) && dec_br &&
                      ((ex_wb_b[0] && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2))) ||
                       (mem_ctrl[1] && (mem_rd != '0) && ((mem_rd == id_rs1) || (mem_rd == id_rs2))));
    assign hz_stall = load_use || br_stall;
    assign issue    = (state == RUN) && !hz_stall;

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ifid_flush = 1'b0;
        if (!dmem_stall) begin
            case (state)
                RUN: begin
                    if (!hz_stall) begin
                        if (id_stop) begin
                            next_state = DRAIN;
                            next_cnt   = CNT_LOAD;
                        end else begin
                            pc_write   = 1'b1;
                            ifid_write = 1'b1;
                            ifid_flush = dec_br && br_taken;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0) next_state = HALT;
                    else           next_cnt   = cnt - 1'b1;
                end
                default: ;
            endcase
        end
        // The front end is left free-running while reset is held.
        if (!rst_n) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
            done  <= 1'b0;
        end else if (!dmem_stall) begin
            state <= next_state;
            cnt   <= next_cnt;
            done  <= (next_state == HALT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl  <= '0;
            ex_mem_b <= '0;
            ex_wb_b  <= '0;
            ex_rd    <= '0;
            ex_rs1   <= '0;
            ex_rs2   <= '0;
            mem_ctrl <= '0;
            mem_wb_b <= '0;
            mem_rd   <= '0;
            wb_ctrl  <= '0;
            wb_rd    <= '0;
        end else if (!dmem_stall) begin
            if (issue && id_valid) begin
                ex_ctrl  <= dec_ex;
                ex_mem_b <= dec_mem;
                ex_wb_b  <= dec_wb;
                ex_rd    <= id_rd;
                ex_rs1   <= id_rs1;
                ex_rs2   <= id_rs2;
            end else begin
                ex_ctrl  <= '0;
                ex_mem_b <= '0;
                ex_wb_b  <= '0;
                ex_rd    <= '0;
                ex_rs1   <= '0;
                ex_rs2   <= '0;
            end
            mem_ctrl <= ex_mem_b;
            mem_wb_b <= ex_wb_b;
            mem_rd   <= ex_rd;
            wb_ctrl  <= mem_wb_b;
            wb_rd    <= mem_rd;
        end
    end

    // The younger producer in MEM wins over WB.
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_wb_b[0] && (mem_rd != '0) && (mem_rd == ex_rs1))     fwd_a = 2'b10;
        else if (wb_ctrl[0] && (wb_rd != '0) && (wb_rd == ex_rs1))   fwd_a = 2'b01;
        if (mem_wb_b[0] && (mem_rd != '0) && (mem_rd == ex_rs2))     fwd_b = 2'b10;
        else if (wb_ctrl[0] && (wb_rd != '0) && (wb_rd == ex_rs2))   fwd_b = 2'b01;
    end

endmodule
